// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the VGA capture path and its timing generator.
// Holds the 640x480 timing defaults, the 3-3-2 colour field widths, the lock FSM
// encoding and a saturating counter increment.
package vga_pkg;

    // 640x480 @ 25 MHz timing, positions counted from the sync-rise sample.
    localparam int unsigned DefHTotal  = 800;
    localparam int unsigned DefVTotal  = 525;
    localparam int unsigned DefHStart  = 144;
    localparam int unsigned DefVStart  = 35;
    localparam int unsigned DefHActive = 640;
    localparam int unsigned DefVActive = 480;

    // 3-3-2 colour packing, pixel = {red, green, blue}.
    localparam int unsigned RedW   = 3;
    localparam int unsigned GreenW = 3;
    localparam int unsigned BlueW  = 2;
    localparam int unsigned PixW   = RedW + GreenW + BlueW;

    // Position counter width; counters saturate at all-ones.
    localparam int unsigned CntW = 10;

    typedef enum logic [1:0] {
        StSearch  = 2'd0,
        StMeasure = 2'd1,
        StLocked  = 2'd2
    } lock_state_e;

    function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] c);
        return (c == {CntW{1'b1}}) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/vga_capture_if.sv
// vga_capture_if: video-in and captured-pixel-out bundle.
//   master: video source / pixel consumer (drives hsync, vsync, red, green, blue)
//   slave : vga_capture (drives pix_valid, pix_x, pix_y, pix_data, frame_start,
//           locked, sync_err)
interface vga_capture_if;
    import vga_pkg::*;

    logic              hsync;
    logic              vsync;
    logic [RedW-1:0]   red;
    logic [GreenW-1:0] green;
    logic [BlueW-1:0]  blue;

    logic              pix_valid;
    logic [CntW-1:0]   pix_x;
    logic [CntW-1:0]   pix_y;
    logic [PixW-1:0]   pix_data;
    logic              frame_start;
    logic              locked;
    logic              sync_err;

    modport master (
        output hsync, vsync, red, green, blue,
        input  pix_valid, pix_x, pix_y, pix_data, frame_start, locked, sync_err
    );

    modport slave (
        input  hsync, vsync, red, green, blue,
        output pix_valid, pix_x, pix_y, pix_data, frame_start, locked, sync_err
    );

endinterface

// File: rtl/vga_sync_counter.sv
// vga_sync_counter: recovers raster position from registered, polarity-normalised syncs.
//   clk_i, rst_ni : pixel clock, async active-low reset
//   hs_i, vs_i    : registered syncs, 1 = asserted
//   hcount_o      : position of the current sample in its line (0 at hsync rise)
//   vcount_o      : line number (0 on the first hsync rise at/after a vsync rise)
//   frame_o       : hsync rise that starts a new frame (qualified vsync rise)
//   h_err_o       : line length violation on this sample
//   v_err_o       : frame length violation on this sample
module vga_sync_counter
    import vga_pkg::*;
#(
    parameter int unsigned H_TOTAL = DefHTotal,
    parameter int unsigned V_TOTAL = DefVTotal
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            hs_i,
    input  logic            vs_i,
    output logic [CntW-1:0] hcount_o,
    output logic [CntW-1:0] vcount_o,
    output logic            frame_o,
    output logic            h_err_o,
    output logic            v_err_o
);

    localparam logic [CntW-1:0] HLast = CntW'(H_TOTAL - 1);
    localparam logic [CntW-1:0] HTot  = CntW'(H_TOTAL);
    localparam logic [CntW-1:0] VLast = CntW'(V_TOTAL - 1);
    localparam logic [CntW-1:0] VTot  = CntW'(V_TOTAL);

    logic            hs_prev_q, vs_prev_q;
    logic            vs_pend_q, vs_pend_d;
    logic [CntW-1:0] h_q, v_q;
    logic            hs_rise, vs_rise;

    // Counts are combinational on the current sample; h_q/v_q hold the previous one.
    always_comb begin
        hs_rise   = hs_i & ~hs_prev_q;
        vs_rise   = vs_i & ~vs_prev_q;
        frame_o   = hs_rise & (vs_rise | vs_pend_q);
        // A vsync rise waits for the next hsync rise unless both coincide.
        vs_pend_d = hs_rise ? 1'b0 : (vs_pend_q | vs_rise);
        hcount_o  = hs_rise ? '0 : sat_inc(h_q);
        if (frame_o) begin
            vcount_o = '0;
        end else if (hs_rise) begin
            vcount_o = sat_inc(v_q);
        end else begin
            vcount_o = v_q;
        end
        h_err_o = (hs_rise && h_q != HLast) || (!hs_rise && hcount_o == HTot);
        // Overlong frame flagged once, on the rise that would start line V_TOTAL.
        v_err_o = (frame_o && v_q != VLast) || (hs_rise && !frame_o && vcount_o == VTot);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hs_prev_q <= 1'b0;
            vs_prev_q <= 1'b0;
            vs_pend_q <= 1'b0;
            h_q       <= '0;
            v_q       <= '0;
        end else begin
            hs_prev_q <= hs_i;
            vs_prev_q <= vs_i;
            vs_pend_q <= vs_pend_d;
            h_q       <= hcount_o;
            v_q       <= vcount_o;
        end
    end

endmodule

// File: rtl/vga_capture.sv
// vga_capture: pixel-clock VGA receiver with timing lock and pixel output.
//   clk25MHz : pixel clock, rising edge
//   rst      : async active-low reset
//   vid      : slave side of vga_capture_if (syncs + RGB in, captured pixels out)
// Pipeline: input register -> position/lock logic -> output register (2 clocks).
module vga_capture
    import vga_pkg::*;
#(
    parameter int unsigned H_TOTAL  = DefHTotal,
    parameter int unsigned V_TOTAL  = DefVTotal,
    parameter int unsigned H_START  = DefHStart,
    parameter int unsigned V_START  = DefVStart,
    parameter int unsigned H_ACTIVE = DefHActive,
    parameter int unsigned V_ACTIVE = DefVActive,
    parameter bit          SYNC_POL = 1'b1
) (
    input  logic          clk25MHz,
    input  logic          rst,
    vga_capture_if.slave  vid
);

    localparam logic [CntW-1:0] HStart = CntW'(H_START);
    localparam logic [CntW-1:0] VStart = CntW'(V_START);
    localparam logic [CntW-1:0] HEnd   = CntW'(H_START + H_ACTIVE);
    localparam logic [CntW-1:0] VEnd   = CntW'(V_START + V_ACTIVE);

    // Input register
    logic            hs_q, vs_q;
    logic [PixW-1:0] rgb_q;

    always_ff @(posedge clk25MHz or negedge rst) begin
        if (!rst) begin
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
            rgb_q <= '0;
        end else begin
            hs_q  <= (vid.hsync == SYNC_POL);
            vs_q  <= (vid.vsync == SYNC_POL);
            rgb_q <= {vid.red, vid.green, vid.blue};
        end
    end

    logic [CntW-1:0] hcount, vcount;
    logic            frame, h_err, v_err, viol;

    vga_sync_counter #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_sync_counter (
        .clk_i    (clk25MHz),
        .rst_ni   (rst),
        .hs_i     (hs_q),
        .vs_i     (vs_q),
        .hcount_o (hcount),
        .vcount_o (vcount),
        .frame_o  (frame),
        .h_err_o  (h_err),
        .v_err_o  (v_err)
    );

    // Lock FSM; err_q remembers a violation seen during the current MEASURE frame.
    lock_state_e state_q, state_d;
    logic        err_q, err_d;

    always_comb begin
        viol    = h_err | v_err;
        state_d = state_q;
        err_d   = err_q;
        unique case (state_q)
            StSearch: begin
                if (frame) begin
                    state_d = StMeasure;
                    err_d   = 1'b0;
                end
            end
            StMeasure: begin
                if (frame) begin
                    if (!err_q && !viol) begin
                        state_d = StLocked;
                    end
                    err_d = 1'b0;
                end else if (viol) begin
                    err_d = 1'b1;
                end
            end
            StLocked: begin
                if (viol) begin
                    state_d = StSearch;
                end
            end
            default: state_d = StSearch;
        endcase
    end

    // Output register
    logic            pix_valid_q, pix_valid_d;
    logic [CntW-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic [PixW-1:0] pix_data_q, pix_data_d;
    logic            frame_start_q, frame_start_d;
    logic            locked_q, locked_d;
    logic            sync_err_q, sync_err_d;
    logic            active;

    always_comb begin
        active = (hcount >= HStart) && (hcount < HEnd) &&
                 (vcount >= VStart) && (vcount < VEnd);
        pix_valid_d   = (state_q == StLocked) && !viol && active;
        frame_start_d = pix_valid_d && (hcount == HStart) && (vcount == VStart);
        locked_d      = (state_d == StLocked);
        sync_err_d    = (state_q == StLocked) && viol;
        pix_x_d       = pix_valid_d ? hcount - HStart : pix_x_q;
        pix_y_d       = pix_valid_d ? vcount - VStart : pix_y_q;
        pix_data_d    = pix_valid_d ? rgb_q : pix_data_q;
    end

    always_ff @(posedge clk25MHz or negedge rst) begin
        if (!rst) begin
            state_q       <= StSearch;
            err_q         <= 1'b0;
            pix_valid_q   <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_data_q    <= '0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            err_q         <= err_d;
            pix_valid_q   <= pix_valid_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            pix_data_q    <= pix_data_d;
            frame_start_q <= frame_start_d;
            locked_q      <= locked_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign vid.pix_valid   = pix_valid_q;
    assign vid.pix_x       = pix_x_q;
    assign vid.pix_y       = pix_y_q;
    assign vid.pix_data    = pix_data_q;
    assign vid.frame_start = frame_start_q;
    assign vid.locked      = locked_q;
    assign vid.sync_err    = sync_err_q;

endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: directed bench for vga_capture.
// The main instance keeps H_START=144 / V_START=35 but uses short totals
// (150 x 40, 6 x 4 active) so several frames fit a short run; a second
// instance uses the 21 x 31 small timing set.
module tb_vga_capture;
    import vga_pkg::*;

    localparam int MHT = 150, MVT = 40, MHS = 144, MVS = 35, MHA = 6, MVA = 4;
    localparam int SHT = 21, SVT = 31, SHS = 5, SVS = 1, SHA = 9, SVA = 13;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #20 clk = ~clk;

    vga_capture_if vif ();
    vga_capture_if vif_s ();

    vga_capture #(
        .H_TOTAL(MHT), .V_TOTAL(MVT), .H_START(MHS), .V_START(MVS),
        .H_ACTIVE(MHA), .V_ACTIVE(MVA), .SYNC_POL(1'b1)
    ) u_dut (
        .clk25MHz (clk),
        .rst      (rst),
        .vid      (vif)
    );

    vga_capture #(
        .H_TOTAL(SHT), .V_TOTAL(SVT), .H_START(SHS), .V_START(SVS),
        .H_ACTIVE(SHA), .V_ACTIVE(SVA), .SYNC_POL(1'b1)
    ) u_small (
        .clk25MHz (clk),
        .rst      (rst),
        .vid      (vif_s)
    );

    int checks = 0, failures = 0;

    // Behavioural source state
    int gh, gv, cur_len, g_htot, g_vtot, g_hsw, g_vsw, last_h, last_v;
    bit hs_off;

    wire [31:0] out_m = {vif.pix_valid, vif.frame_start, vif.locked, vif.sync_err,
                         vif.pix_x, vif.pix_y, vif.pix_data};

    // Output monitors
    int cnt_m = 0, fs_m = 0, fs0_m = 0, err_m = 0, run_m = 0, bad_run_m = 0;
    int cnt_s = 0, fs_s = 0, lastx_s = 0, lasty_s = 0, bad_s = 0;

    always @(negedge clk) begin
        if (vif.pix_valid === 1'b1) begin
            cnt_m++;
            run_m++;
        end else begin
            if (run_m != 0 && run_m != MHA) bad_run_m++;
            run_m = 0;
        end
        if (vif.frame_start === 1'b1) begin
            fs_m++;
            if (vif.pix_valid === 1'b1 && vif.pix_x == 0 && vif.pix_y == 0) fs0_m++;
        end
        if (vif.sync_err === 1'b1) err_m++;
        if (vif_s.pix_valid === 1'b1) begin
            cnt_s++;
            lastx_s = int'(vif_s.pix_x);
            lasty_s = int'(vif_s.pix_y);
            if (vif_s.pix_x > 10'd8 || vif_s.pix_y > 10'd12) bad_s++;
        end
        if (vif_s.frame_start === 1'b1) fs_s++;
    end

    // One pixel clock of source output; pins change 1 time unit after the edge.
    task automatic step();
        logic [7:0] d;
        logic       hs, vs;
        @(posedge clk);
        #1;
        d  = (gh == 149 && gv == 38) ? 8'hA5 : 8'h00;
        hs = (gh < g_hsw) && !hs_off;
        vs = (gv < g_vsw);
        vif.hsync   = hs;
        vif.vsync   = vs;
        vif.red     = d[7:5];
        vif.green   = d[4:2];
        vif.blue    = d[1:0];
        vif_s.hsync = hs;
        vif_s.vsync = vs;
        vif_s.red   = d[7:5];
        vif_s.green = d[4:2];
        vif_s.blue  = d[1:0];
        last_h = gh;
        last_v = gv;
        gh++;
        if (gh >= cur_len) begin
            gh      = 0;
            cur_len = g_htot;
            gv      = (gv + 1 >= g_vtot) ? 0 : gv + 1;
        end
    endtask

    task automatic run_to(input int h, input int v);
        int n = 0;
        do begin
            step();
            n++;
        end while (!(last_h == h && last_v == v) && n < 20000);
        checks++;
        if (!(last_h == h && last_v == v)) begin
            failures++;
            $display("FAIL run_to: reached h=%0d v=%0d, required h=%0d v=%0d", last_h, last_v, h, v);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        g_htot = MHT; g_vtot = MVT; g_hsw = 96; g_vsw = 2;
        gh = 0; gv = MVT - 2; cur_len = MHT; hs_off = 1'b0;
        step();
        step();
        checks++;
        if (out_m !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs: got %h required 0", out_m);
        end
        checks++;
        if (u_dut.state_q !== StSearch) begin
            failures++;
            $display("FAIL reset_state: got %0d required %0d", u_dut.state_q, StSearch);
        end
        rst = 1'b1;
    endtask

    task automatic test_lock();
        int c0, f0, z0, b0, e0;
        run_to(0, 0);
        step(); step();
        checks++;
        if (vif.locked !== 1'b0 || u_dut.state_q !== StMeasure) begin
            failures++;
            $display("FAIL lock_first_rise: locked=%b state=%0d required 0/1", vif.locked, u_dut.state_q);
        end
        run_to(0, 0);
        step();
        checks++;
        if (vif.locked !== 1'b0) begin
            failures++;
            $display("FAIL lock_not_early: locked=%b required 0", vif.locked);
        end
        step();
        checks++;
        if (vif.locked !== 1'b1) begin
            failures++;
            $display("FAIL lock_second_rise: locked=%b required 1", vif.locked);
        end
        c0 = cnt_m; f0 = fs_m; z0 = fs0_m; b0 = bad_run_m; e0 = err_m;
        run_to(0, 0);
        step(); step();
        checks++;
        if (cnt_m - c0 != MHA * MVA) begin
            failures++;
            $display("FAIL frame_pixels: got %0d required %0d", cnt_m - c0, MHA * MVA);
        end
        checks++;
        if (fs_m - f0 != 1 || fs0_m - z0 != 1) begin
            failures++;
            $display("FAIL frame_start: got %0d/%0d at origin, required 1/1", fs_m - f0, fs0_m - z0);
        end
        checks++;
        if (bad_run_m - b0 != 0 || err_m - e0 != 0) begin
            failures++;
            $display("FAIL clean_frame: bubbles=%0d errs=%0d required 0/0", bad_run_m - b0, err_m - e0);
        end
    endtask

    task automatic test_align();
        run_to(149, 38);
        step();
        checks++;
        if (vif.pix_valid !== 1'b1 || vif.pix_x !== 10'd4 || vif.pix_data !== 8'h00) begin
            failures++;
            $display("FAIL align_pre: v=%b x=%0d d=%h required 1/4/00", vif.pix_valid, vif.pix_x, vif.pix_data);
        end
        step();
        checks++;
        if (vif.pix_valid !== 1'b1 || vif.pix_x !== 10'd5 || vif.pix_y !== 10'd3 ||
            vif.pix_data !== 8'hA5) begin
            failures++;
            $display("FAIL align_hit: v=%b x=%0d y=%0d d=%h required 1/5/3/a5",
                     vif.pix_valid, vif.pix_x, vif.pix_y, vif.pix_data);
        end
        step();
        checks++;
        if (vif.pix_valid !== 1'b0 || vif.pix_x !== 10'd5 || vif.pix_data !== 8'hA5) begin
            failures++;
            $display("FAIL align_hold: v=%b x=%0d d=%h required 0/5/a5", vif.pix_valid, vif.pix_x, vif.pix_data);
        end
    endtask

    // Relock takes two further vsync rises; no pixels may appear before it.
    task automatic relock_check(input string name);
        int c0;
        c0 = cnt_m;
        run_to(0, 0);
        step(); step();
        checks++;
        if (vif.locked !== 1'b0) begin
            failures++;
            $display("FAIL %s_measure: locked=%b required 0", name, vif.locked);
        end
        run_to(0, 0);
        step(); step();
        checks++;
        if (vif.locked !== 1'b1 || cnt_m - c0 != 0) begin
            failures++;
            $display("FAIL %s_relock: locked=%b pixels=%0d required 1/0", name, vif.locked, cnt_m - c0);
        end
    endtask

    task automatic test_short_line();
        int e0;
        e0 = err_m;
        run_to(149, 9);
        cur_len = MHT - 1;
        run_to(0, 11);
        step();
        checks++;
        if (vif.sync_err !== 1'b0 || vif.locked !== 1'b1) begin
            failures++;
            $display("FAIL short_pre: err=%b locked=%b required 0/1", vif.sync_err, vif.locked);
        end
        step();
        checks++;
        if ({vif.sync_err, vif.locked, vif.pix_valid} !== 3'b100) begin
            failures++;
            $display("FAIL short_err: err/locked/valid=%b required 100",
                     {vif.sync_err, vif.locked, vif.pix_valid});
        end
        step();
        checks++;
        if (vif.sync_err !== 1'b0 || err_m - e0 != 1) begin
            failures++;
            $display("FAIL short_pulse: err=%b pulses=%0d required 0/1", vif.sync_err, err_m - e0);
        end
        relock_check("short");
    endtask

    task automatic test_missing_hsync();
        run_to(149, 4);
        hs_off = 1'b1;
        run_to(0, 5);
        step();
        checks++;
        if (vif.sync_err !== 1'b0) begin
            failures++;
            $display("FAIL nohs_early: err=%b required 0", vif.sync_err);
        end
        step();
        checks++;
        if ({vif.sync_err, vif.locked} !== 2'b10) begin
            failures++;
            $display("FAIL nohs_err: err/locked=%b required 10", {vif.sync_err, vif.locked});
        end
        run_to(149, 12);
        hs_off = 1'b0;
        relock_check("nohs");
    endtask

    task automatic test_reset_mid();
        run_to(0, 20);
        checks++;
        if (vif.locked !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre: locked=%b required 1", vif.locked);
        end
        #5;
        rst = 1'b0;
        #1;
        checks++;
        if (out_m !== 32'h0 || u_dut.state_q !== StSearch) begin
            failures++;
            $display("FAIL rstmid_async: out=%h state=%0d required 0/0", out_m, u_dut.state_q);
        end
        step(); step(); step();
        rst = 1'b1;
        relock_check("rstmid");
    endtask

    task automatic test_small();
        int c0, f0, b0;
        g_htot = SHT; g_vtot = SVT; g_hsw = 2; g_vsw = 1;
        gh = 0; gv = SVT - 2; cur_len = SHT;
        rst = 1'b0;
        step(); step();
        rst = 1'b1;
        run_to(0, 0);
        step(); step();
        checks++;
        if (vif_s.locked !== 1'b0) begin
            failures++;
            $display("FAIL small_measure: locked=%b required 0", vif_s.locked);
        end
        run_to(0, 0);
        step(); step();
        checks++;
        if (vif_s.locked !== 1'b1) begin
            failures++;
            $display("FAIL small_lock: locked=%b required 1", vif_s.locked);
        end
        c0 = cnt_s; f0 = fs_s; b0 = bad_s;
        run_to(0, 0);
        step(); step();
        checks++;
        if (cnt_s - c0 != SHA * SVA || fs_s - f0 != 1) begin
            failures++;
            $display("FAIL small_count: pixels=%0d fs=%0d required %0d/1", cnt_s - c0, fs_s - f0, SHA * SVA);
        end
        checks++;
        if (lastx_s != 8 || lasty_s != 12 || bad_s - b0 != 0) begin
            failures++;
            $display("FAIL small_bounds: last=(%0d,%0d) outside=%0d required (8,12)/0",
                     lastx_s, lasty_s, bad_s - b0);
        end
    endtask

    initial begin
        vif.hsync = 1'b0; vif.vsync = 1'b0; vif.red = '0; vif.green = '0; vif.blue = '0;
        vif_s.hsync = 1'b0; vif_s.vsync = 1'b0; vif_s.red = '0; vif_s.green = '0; vif_s.blue = '0;
        test_reset();
        test_lock();
        test_align();
        test_short_line();
        test_missing_hsync();
        test_reset_mid();
        test_small();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_capture.md
# vga_capture

Pixel-clock-synchronous VGA receiver for 640x480 at 25 MHz; the sink-side counterpart of the VGA timing generator. It samples hsync, vsync and 8-bit RGB (3-3-2) on the pixel clock and recovers horizontal and vertical position. It checks the incoming timing against the configured totals and, once locked, emits one valid pixel per active-area sample with its coordinates. It is used for loopback self-test of the display path and for feeding a frame buffer.

## Interface
- H_TOTAL, 800: clocks per line.
- V_TOTAL, 525: lines per frame.
- H_START, 144: first active h position, counted from the sync-rise sample (h=0).
- V_START, 35: first active line, counted from the vsync line (v=0).
- H_ACTIVE, 640: active pixels per line.
- V_ACTIVE, 480: active lines per frame.
- SYNC_POL, 1: asserted level of hsync/vsync; 1 means active-high.

Ports:
- clk25MHz  in  1  pixel clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- hsync  in  1  horizontal sync.
- vsync  in  1  vertical sync.
- red  in  3  red component.
- green  in  3  green component.
- blue  in  2  blue component.
- pix_valid  out  1  pix_x, pix_y and pix_data hold an active pixel.
- pix_x  out  10  active column, 0..H_ACTIVE-1.
- pix_y  out  10  active row, 0..V_ACTIVE-1.
- pix_data  out  8  pixel value {red, green, blue}.
- frame_start  out  1  pulse coincident with pixel (0,0).
- locked  out  1  timing verified.
- sync_err  out  1  one-cycle pulse on timing violation.

## Operation
- **Stage 1 (input register):** all inputs are registered on every clock. All subsequent logic sees only the registered copies. The sync inputs are normalised by SYNC_POL.
- **Horizontal edge:** a sync rise is a sample asserted where the previous sample was deasserted.
- **hcount:** 0 at an hsync-rise sample, otherwise the previous value +1. It saturates at 1023.
- **vcount:** 0 at the first hsync rise at or after a vsync rise (a vsync rise coincident with an hsync rise gives v=0 on that line). Otherwise vcount increments on each hsync rise and saturates at 1023.
- **Active area:** H_START <= hcount < H_START+H_ACTIVE and V_START <= vcount < V_START+V_ACTIVE.
  - pix_x = hcount-H_START.
  - pix_y = vcount-V_START.
- **Lock FSM, SEARCH -> MEASURE -> LOCKED:**
  - SEARCH: wait for a vsync rise, then go to MEASURE.
  - MEASURE: check one full frame. At the next vsync rise, if every line was exactly H_TOTAL clocks and the frame was exactly V_TOTAL lines, go to LOCKED. Otherwise stay in MEASURE and restart the check.
  - LOCKED: locked=1.
- **Violations (checked in MEASURE and LOCKED):**
  - an hsync rise with previous hcount != H_TOTAL-1;
  - hcount reaching H_TOTAL with no rise;
  - a vsync rise with previous vcount != V_TOTAL-1 (qualified at the hsync rise);
  - vcount reaching V_TOTAL.
- **On a violation:**
  - In LOCKED: pulse sync_err for one clock, drop locked and pix_valid on the same cycle, go to SEARCH.
  - In MEASURE: no sync_err pulse; restart the measurement.
- **pix_valid** asserts only in LOCKED, and only inside the active area.
- **frame_start** asserts only with pix_valid at pixel (0,0).
- **Data outputs:** pix_x, pix_y and pix_data update only when pix_valid is 1 and hold their last value otherwise.
- **Reset:** asynchronous. Every output is 0, all counters are 0, the FSM is in SEARCH and the input-register contents are 0. Reset mid-frame discards all progress.

## Timing
- **Pixel latency:** pins at edge t appear as pix_data/pix_valid after edge t+2 (input register, then output register).
- **locked** rises on the output register, in the same cycle position as the pix_* outputs for the vsync-rise sample that completes a clean MEASURE frame. Lock is never earlier than the second observed vsync rise.
- **sync_err timing:** sync_err is on the output register, 2 clocks after the offending pin sample. locked falls on that same edge.
- **Back-to-back pixels:** a valid pixel every clock within an active line, with no bubbles.

## Structure
- A shared package `vga_pkg` holds:
  - the timing defaults (H_TOTAL, V_TOTAL, H_START, V_START, H_ACTIVE, V_ACTIVE);
  - the 3-3-2 colour field widths;
  - the FSM state encoding (SEARCH=0, MEASURE=1, LOCKED=2).
- The same defaults are used by the timing generator.
- One sub-module, `vga_sync_counter`: it takes the registered syncs and produces hcount, vcount, the rise strobes and the violation flags. The FSM and output register live in the top level.

## Test plan
1. **Clean frames.** Reset, then clean 800x525 frames from a behavioural source.
   - locked=1 at the 2nd vsync rise.
   - The next frame gives exactly 307200 pix_valid cycles.
   - frame_start coincides once with (0,0).
2. **Data alignment.** Source drives {r,g,b} = 8'hA5 at h=149, v=38, other pixels 0.
   - pix_valid with pix_x=5, pix_y=3, pix_data=8'hA5 appears exactly 2 clocks later.
3. **Short line.** One line of 799 clocks while locked.
   - sync_err is a single-cycle pulse; locked=0 and pix_valid=0 on the same edge.
   - Relock occurs after two further clean vsync rises.
4. **Missing hsync.** hsync held deasserted while locked.
   - sync_err fires when hcount reaches 800.
   - No pix_valid until relock.
5. **Reset mid-frame.** Assert rst at line 200.
   - All outputs are 0 immediately (asynchronously) and the FSM is in SEARCH.
   - After release, locked only after a full clean MEASURE frame.
6. **Small parameter set.** H_TOTAL=21, V_TOTAL=31, H_START=5, V_START=1, H_ACTIVE=9, V_ACTIVE=13.
   - The last pixel is (8,12).
   - No pixel is emitted at h=14 or v=14.
